// File: rtl/rscl_mem_arbiter_pkg.sv
// Shared types for the core memory-port arbiter: request/response payloads,
// arbiter state encoding and the grant vector bit positions.
package rscl_mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;
    localparam int CNT_W  = 4;             // holds STARVE_MAX up to 15

    localparam int GNT_IF = 0;             // grant vector bit for instruction fetch
    localparam int GNT_D  = 1;             // grant vector bit for load/store

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t             addr;
        logic              we;
        logic [STRB_W-1:0] wstrb;
        word_t             wdata;
    } mem_req_t;

    typedef struct packed {
        word_t data;
        logic  err;
    } mem_resp_t;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_REQ_I,
        ARB_REQ_D,
        ARB_WAIT_I,
        ARB_WAIT_D
    } arb_state_t;

    // Fetches are always word reads: no write enable, no strobes, no data.
    function automatic mem_req_t fetch_req(input word_t addr);
        mem_req_t r;
        r.addr  = addr;
        r.we    = 1'b0;
        r.wstrb = '0;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/rscl_mem_arbiter_prio.sv
// Two-way priority grant between fetch and load/store. Load/store wins
// contention until it has won STARVE_MAX contended grants in a row, then
// fetch is forced through once.
module rscl_arb_prio
    import rscl_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_valid_i,
    input  logic       d_valid_i,
    input  logic       grant_en_i,
    output logic [1:0] gnt_o
);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Grant selection and starvation counter next state.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt_o        = '0;
        starve_cnt_d = starve_cnt_q;
        if (grant_en_i) begin
            if (if_valid_i && (!d_valid_i || starved)) begin
                gnt_o[GNT_IF] = 1'b1;
            end else if (d_valid_i) begin
                gnt_o[GNT_D] = 1'b1;
            end
        end
        if (gnt_o[GNT_IF]) begin
            starve_cnt_d = '0;
        end else if (gnt_o[GNT_D] && if_valid_i && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/rscl_mem_arbiter.sv
// Shares the single core memory port between instruction fetch and the
// load/store path. One bus transaction is outstanding at a time; the request
// side is fully registered, responses are forwarded combinationally.
module rscl_mem_arbiter
    import rscl_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,         // must equal WORD_W
    parameter int DATA_W     = 32          // must equal WORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    output logic                if_resp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                d_resp_err,
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic [ADDR_W-1:0]   bus_req_addr,
    output logic                bus_req_we,
    output logic [DATA_W/8-1:0] bus_req_wstrb,
    output logic [DATA_W-1:0]   bus_req_wdata,
    input  logic                bus_resp_valid,
    input  logic [DATA_W-1:0]   bus_resp_data,
    input  logic                bus_resp_err
);

    arb_state_t state_q;
    mem_req_t   req_q;
    logic       bus_req_valid_q;
    logic       drop_q;            // in-flight fetch was redirected; swallow its response
    logic [1:0] gnt;
    logic       grant_en;
    mem_resp_t  bus_resp;

    // Grants are only offered in IDLE and never while reset is held, so the
    // ready outputs are quiet during reset even if requesters are asserting.
    assign grant_en = (state_q == ARB_IDLE) && rst_n;

    rscl_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid_i (if_req_valid),
        .d_valid_i  (d_req_valid),
        .grant_en_i (grant_en),
        .gnt_o      (gnt)
    );

    assign if_req_ready = gnt[GNT_IF];
    assign d_req_ready  = gnt[GNT_D];

    assign bus_req_valid = bus_req_valid_q;
    assign bus_req_addr  = req_q.addr;
    assign bus_req_we    = req_q.we;
    assign bus_req_wstrb = req_q.wstrb;
    assign bus_req_wdata = req_q.wdata;

    // Response routing: only the side whose transaction is waiting sees it,
    // and a flushed fetch (earlier or this very cycle) is swallowed.
    assign bus_resp.data = bus_resp_data;
    assign bus_resp.err  = bus_resp_err;

    assign if_resp_valid = (state_q == ARB_WAIT_I) && bus_resp_valid && !drop_q && !if_flush;
    assign if_resp_data  = if_resp_valid ? bus_resp.data : '0;
    assign if_resp_err   = if_resp_valid && bus_resp.err;

    assign d_resp_valid  = (state_q == ARB_WAIT_D) && bus_resp_valid;
    assign d_resp_data   = d_resp_valid ? bus_resp.data : '0;
    assign d_resp_err    = d_resp_valid && bus_resp.err;

    // Transaction FSM with registered bus request and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ARB_IDLE;
            req_q           <= '0;
            bus_req_valid_q <= 1'b0;
            drop_q          <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (gnt[GNT_IF]) begin
                        state_q         <= ARB_REQ_I;
                        req_q           <= fetch_req(if_req_addr);
                        bus_req_valid_q <= 1'b1;
                        drop_q          <= if_flush;
                    end else if (gnt[GNT_D]) begin
                        state_q         <= ARB_REQ_D;
                        req_q.addr      <= d_req_addr;
                        req_q.we        <= d_req_we;
                        req_q.wstrb     <= d_req_wstrb;
                        req_q.wdata     <= d_req_wdata;
                        bus_req_valid_q <= 1'b1;
                    end
                end
                ARB_REQ_I: begin
                    if (if_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_req_ready) begin
                        bus_req_valid_q <= 1'b0;
                        state_q         <= ARB_WAIT_I;
                    end
                end
                ARB_REQ_D: begin
                    if (bus_req_ready) begin
                        bus_req_valid_q <= 1'b0;
                        state_q         <= ARB_WAIT_D;
                    end
                end
                ARB_WAIT_I: begin
                    if (bus_resp_valid) begin
                        drop_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end else if (if_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                ARB_WAIT_D: begin
                    if (bus_resp_valid) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rscl_mem_arbiter.sv
// Self-checking bench for rscl_mem_arbiter. The bench plays both requesters
// and the memory bus; expected responses go into a scoreboard queue when the
// bus response is driven and are popped when the arbiter forwards one.
module tb_rscl_mem_arbiter;

    localparam int STARVE_MAX = 4;

    typedef struct {
        logic        side;     // 0 = fetch, 1 = load/store
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_resp_err;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_req_wdata;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_resp_err;

    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    rscl_mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_addr    (if_req_addr),
        .if_flush       (if_flush),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .if_resp_err    (if_resp_err),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_req_addr     (d_req_addr),
        .d_req_we       (d_req_we),
        .d_req_wstrb    (d_req_wstrb),
        .d_req_wdata    (d_req_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .d_resp_err     (d_resp_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_we     (bus_req_we),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_req_wdata  (bus_req_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data),
        .bus_resp_err   (bus_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every forwarded response must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (if_resp_valid) begin
            if (sb_q.size() == 0) begin
                check("if_resp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("if_resp_side", 0, e.side);
                check("if_resp_data", if_resp_data, e.data);
                check("if_resp_err", if_resp_err, e.err);
            end
        end
        if (d_resp_valid) begin
            if (sb_q.size() == 0) begin
                check("d_resp_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("d_resp_side", 1, e.side);
                check("d_resp_data", d_resp_data, e.data);
                check("d_resp_err", d_resp_err, e.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic side, input logic [31:0] data, input logic err);
        exp_t e;
        e.side = side;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_bus_valid"}, bus_req_valid, 0);
        check({tag, "_bus_addr"}, bus_req_addr, 0);
        check({tag, "_bus_we"}, bus_req_we, 0);
        check({tag, "_bus_wstrb"}, bus_req_wstrb, 0);
        check({tag, "_bus_wdata"}, bus_req_wdata, 0);
        check({tag, "_if_ready"}, if_req_ready, 0);
        check({tag, "_d_ready"}, d_req_ready, 0);
        check({tag, "_if_resp"}, if_resp_valid, 0);
        check({tag, "_d_resp"}, d_resp_valid, 0);
    endtask

    // One complete transaction from IDLE, bus accepting at once.
    // flush_mode: 0 none, 1 flush one cycle before response, 2 flush with response.
    task automatic run_txn(input logic side, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic rerr, input int resp_gap, input int flush_mode);
        bus_req_ready = 1'b1;
        if (side) begin
            d_req_valid = 1'b1;
            d_req_addr  = addr;
            d_req_we    = 1'b0;
            d_req_wstrb = 4'h0;
            d_req_wdata = 32'h0;
        end else begin
            if_req_valid = 1'b1;
            if_req_addr  = addr;
        end
        @(negedge clk);
        check("txn_grant", {if_req_ready, d_req_ready}, side ? 2'b01 : 2'b10);
        step();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        @(negedge clk);
        check("txn_bus_valid", bus_req_valid, 1);
        check("txn_bus_addr", bus_req_addr, addr);
        check("txn_bus_we", bus_req_we, 0);
        step();
        for (int i = 0; i < resp_gap; i++) step();
        if (flush_mode == 1) begin
            if_flush = 1'b1;
            step();
            if_flush = 1'b0;
        end
        bus_resp_valid = 1'b1;
        bus_resp_data  = rdata;
        bus_resp_err   = rerr;
        if (flush_mode == 2) if_flush = 1'b1;
        if (flush_mode == 0) push_exp(side, rdata, rerr);
        @(negedge clk);
        if (flush_mode != 0) check("flush_suppress", if_resp_valid, 0);
        step();
        bus_resp_valid = 1'b0;
        bus_resp_data  = 32'h0;
        bus_resp_err   = 1'b0;
        if_flush       = 1'b0;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h0;
        if_flush       = 1'b0;
        d_req_valid    = 1'b1;
        d_req_addr     = 32'h0;
        d_req_we       = 1'b0;
        d_req_wstrb    = 4'h0;
        d_req_wdata    = 32'h0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_data  = 32'h0;
        bus_resp_err   = 1'b0;

        // Reset state, with requesters asserting to show ready stays low.
        repeat (2) @(negedge clk);
        check_quiet("reset");
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fetch only, response a few cycles after acceptance.
        run_txn(1'b0, 32'h0000_0100, 32'h0000_0013, 1'b0, 2, 0);

        // Both requesting every cycle: D,D,D,D,IF,D,D,D,D,IF.
        if_req_addr   = 32'h0000_0400;
        d_req_addr    = 32'h0000_0500;
        d_req_we      = 1'b0;
        bus_req_ready = 1'b1;
        if_req_valid  = 1'b1;
        d_req_valid   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic exp_if;
            exp_if = (k == 4) || (k == 9);
            @(negedge clk);
            check($sformatf("grant_order_%0d", k), {if_req_ready, d_req_ready},
                  exp_if ? 2'b10 : 2'b01);
            step();
            step();
            bus_resp_valid = 1'b1;
            bus_resp_data  = 32'h100 + k;
            push_exp(!exp_if, 32'h100 + k, 1'b0);
            step();
            bus_resp_valid = 1'b0;
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        step();

        // Store held off by the bus for 5 cycles: payload must not move.
        bus_req_ready = 1'b0;
        d_req_valid   = 1'b1;
        d_req_addr    = 32'h0000_2000;
        d_req_we      = 1'b1;
        d_req_wstrb   = 4'b0011;
        d_req_wdata   = 32'hABCD_1234;
        @(negedge clk);
        check("store_grant", d_req_ready, 1);
        step();
        d_req_valid = 1'b0;
        d_req_addr  = 32'hFFFF_FFFF;
        d_req_we    = 1'b0;
        d_req_wstrb = 4'hF;
        d_req_wdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("store_valid", bus_req_valid, 1);
            check("store_addr", bus_req_addr, 32'h0000_2000);
            check("store_we", bus_req_we, 1);
            check("store_wstrb", bus_req_wstrb, 4'b0011);
            check("store_wdata", bus_req_wdata, 32'hABCD_1234);
            step();
        end
        bus_req_ready = 1'b1;
        step();
        bus_resp_valid = 1'b1;
        bus_resp_data  = 32'h0;
        push_exp(1'b1, 32'h0, 1'b0);
        step();
        bus_resp_valid = 1'b0;
        step();

        // Flushed fetches: flush before the error response, and flush with it.
        run_txn(1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 0, 1);
        run_txn(1'b0, 32'h0000_0204, 32'hCAFE_0001, 1'b0, 0, 2);
        run_txn(1'b0, 32'h0000_0208, 32'h0000_0055, 1'b0, 0, 0);

        // Response while the request is still pending on the bus is ignored.
        bus_req_ready = 1'b0;
        d_req_valid   = 1'b1;
        d_req_addr    = 32'h0000_3000;
        d_req_we      = 1'b0;
        step();
        d_req_valid    = 1'b0;
        bus_resp_valid = 1'b1;
        bus_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("early_resp_d", d_resp_valid, 0);
        check("early_resp_if", if_resp_valid, 0);
        check("early_req_held", bus_req_valid, 1);
        step();
        bus_resp_valid = 1'b0;
        bus_req_ready  = 1'b1;
        step();
        bus_resp_valid = 1'b1;
        bus_resp_data  = 32'h0000_0077;
        push_exp(1'b1, 32'h0000_0077, 1'b0);
        step();
        bus_resp_valid = 1'b0;
        step();

        // Reset in WAIT_D, then a late response after release.
        d_req_valid = 1'b1;
        d_req_addr  = 32'h0000_4000;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        step();
        d_req_valid = 1'b0;
        rst_n       = 1'b1;
        step();
        bus_resp_valid = 1'b1;
        bus_resp_data  = 32'h1111_2222;
        @(negedge clk);
        check("late_resp_d", d_resp_valid, 0);
        check("late_resp_bus", bus_req_valid, 0);
        step();
        bus_resp_valid = 1'b0;

        // Arbiter still healthy afterwards.
        run_txn(1'b1, 32'h0000_5000, 32'h0000_0099, 1'b1, 1, 0);

        repeat (2) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
